// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave front-end for the tlk2711_top single-cycle register bus.
// The AW, W and AR channels are captured into holding registers. Reads and
// writes are then serialised onto reg_wen/reg_ren one access at a time.
// Each access returns an OKAY, SLVERR or DECERR response.
//
// Ports:
//   ps_clk, ps_rst_n      bridge clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*      AXI4-Lite write address, data and response channels
//   s_axil_ar*/r*         AXI4-Lite read address and data channels
//   reg_wen/waddr/wdata   register write strobe, address and data (to i_reg_*)
//   reg_ren/raddr         register read strobe and address (to i_reg_*)
//   reg_rdata             register read data (from o_reg_rdata)
module tlk2711_axil_reg_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned REG_ADDR_WIDTH = 16,
    parameter int unsigned REG_SPAN       = 16'h0080,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                      ps_clk,
    input  logic                      ps_rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [63:0]               s_axil_wdata,
    input  logic [7:0]                s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [63:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [63:0]               reg_wdata,
    output logic                      reg_ren,
    output logic [REG_ADDR_WIDTH-1:0] reg_raddr,
    input  logic [63:0]               reg_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(REG_SPAN);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t state, state_next;

    logic                      aw_held, w_held, ar_held;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [63:0]               wdata_q;
    logic [7:0]                wstrb_q;
    logic                      last_grant_read;
    logic [2:0]                lat_cnt;
    logic [1:0]                bresp_q, rresp_q;
    logic [63:0]               rdata_q;
    logic                      write_pend, read_pend, contention;
    logic                      grant_wr, grant_rd;
    logic [1:0]                wr_check, rd_check;
    logic                      aw_hs, w_hs, ar_hs, b_hs, r_hs;

    // Readies are simply "holding register empty"; they refill on B/R handshake.
    assign s_axil_awready = ~aw_held;
    assign s_axil_wready  = ~w_held;
    assign s_axil_arready = ~ar_held;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    assign aw_hs = s_axil_awvalid & ~aw_held;
    assign w_hs  = s_axil_wvalid & ~w_held;
    assign ar_hs = s_axil_arvalid & ~ar_held;
    assign b_hs  = (state == WR_RESP) & s_axil_bready;
    assign r_hs  = (state == RD_RESP) & s_axil_rready;

    // On contention the direction opposite to the last contended grant wins.
    assign write_pend = aw_held & w_held;
    assign read_pend  = ar_held;
    assign contention = write_pend & read_pend;
    assign grant_wr   = (state == IDLE) & write_pend & (~read_pend | last_grant_read);
    assign grant_rd   = (state == IDLE) & read_pend & (~write_pend | ~last_grant_read);

    always_comb begin
        wr_check = RESP_OKAY;
        if (awaddr_q >= SPAN)
            wr_check = RESP_DECERR;
        else if (awaddr_q[2:0] != 3'b000)
            wr_check = RESP_SLVERR;
        else if (wstrb_q != 8'hFF)
            wr_check = RESP_SLVERR;
    end

    always_comb begin
        rd_check = RESP_OKAY;
        if (araddr_q >= SPAN)
            rd_check = RESP_DECERR;
        else if (araddr_q[2:0] != 3'b000)
            rd_check = RESP_SLVERR;
    end

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        reg_wen       = 1'b0;
        reg_ren       = 1'b0;
        s_axil_bvalid = 1'b0;
        s_axil_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr)
                    state_next = WR_ISSUE;
                else if (grant_rd)
                    state_next = RD_ISSUE;
            end
            WR_ISSUE: begin
                reg_wen    = (bresp_q == RESP_OKAY);
                state_next = WR_RESP;
            end
            WR_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready)
                    state_next = IDLE;
            end
            RD_ISSUE: begin
                reg_ren    = (rresp_q == RESP_OKAY);
                state_next = (rresp_q == RESP_OKAY) ? RD_WAIT : RD_RESP;
            end
            RD_WAIT: begin
                if (lat_cnt == LAT)
                    state_next = RD_RESP;
            end
            RD_RESP: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            ar_held         <= 1'b0;
            awaddr_q        <= '0;
            araddr_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            last_grant_read <= 1'b1;
            lat_cnt         <= '0;
            bresp_q         <= '0;
            rresp_q         <= '0;
            rdata_q         <= '0;
            reg_waddr       <= '0;
            reg_wdata       <= '0;
            reg_raddr       <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end
            if (ar_hs) begin
                ar_held  <= 1'b1;
                araddr_q <= s_axil_araddr;
            end
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (r_hs)
                ar_held <= 1'b0;

            // Response and bus address are resolved while leaving IDLE so the
            // ISSUE state only has to look at a registered response code.
            if (grant_wr) begin
                bresp_q <= wr_check;
                if (wr_check == RESP_OKAY) begin
                    reg_waddr <= awaddr_q[REG_ADDR_WIDTH-1:0];
                    reg_wdata <= wdata_q;
                end
                if (contention)
                    last_grant_read <= 1'b0;
            end
            if (grant_rd) begin
                rresp_q <= rd_check;
                if (rd_check == RESP_OKAY)
                    reg_raddr <= araddr_q[REG_ADDR_WIDTH-1:0];
                if (contention)
                    last_grant_read <= 1'b1;
            end

            if (state == RD_ISSUE) begin
                lat_cnt <= 3'd1;
                if (rresp_q != RESP_OKAY)
                    rdata_q <= '0;
            end
            if (state == RD_WAIT) begin
                if (lat_cnt == LAT)
                    rdata_q <= reg_rdata;
                else
                    lat_cnt <= lat_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Directed self-checking bench for tlk2711_axil_reg_bridge.
// dut1 uses READ_LATENCY=1 and carries most traffic. dut3 uses READ_LATENCY=3.
// Each register-file model presents read data only on the cycle that is
// READ_LATENCY cycles after the reg_ren pulse.
module tb_tlk2711_axil_reg_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut1 signals
    logic [31:0] awaddr1 = '0, araddr1 = '0;
    logic        awvalid1 = 1'b0, wvalid1 = 1'b0, arvalid1 = 1'b0;
    logic        bready1 = 1'b1, rready1 = 1'b1;
    logic [63:0] wdata1 = '0;
    logic [7:0]  wstrb1 = '0;
    logic        awready1, wready1, arready1, bvalid1, rvalid1;
    logic [1:0]  bresp1, rresp1;
    logic [63:0] rdata1;
    logic        reg_wen1, reg_ren1;
    logic [15:0] reg_waddr1, reg_raddr1;
    logic [63:0] reg_wdata1, reg_rdata1;

    // dut3 signals
    logic [31:0] araddr3 = '0;
    logic        arvalid3 = 1'b0;
    logic        awready3, wready3, arready3, bvalid3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [63:0] rdata3;
    logic        reg_wen3, reg_ren3;
    logic [15:0] reg_waddr3, reg_raddr3;
    logic [63:0] reg_wdata3, reg_rdata3;

    tlk2711_axil_reg_bridge #(.READ_LATENCY(1)) dut1 (
        .ps_clk(clk), .ps_rst_n(rst_n),
        .s_axil_awaddr(awaddr1), .s_axil_awvalid(awvalid1), .s_axil_awready(awready1),
        .s_axil_wdata(wdata1), .s_axil_wstrb(wstrb1), .s_axil_wvalid(wvalid1),
        .s_axil_wready(wready1), .s_axil_bresp(bresp1), .s_axil_bvalid(bvalid1),
        .s_axil_bready(bready1), .s_axil_araddr(araddr1), .s_axil_arvalid(arvalid1),
        .s_axil_arready(arready1), .s_axil_rdata(rdata1), .s_axil_rresp(rresp1),
        .s_axil_rvalid(rvalid1), .s_axil_rready(rready1),
        .reg_wen(reg_wen1), .reg_waddr(reg_waddr1), .reg_wdata(reg_wdata1),
        .reg_ren(reg_ren1), .reg_raddr(reg_raddr1), .reg_rdata(reg_rdata1)
    );

    tlk2711_axil_reg_bridge #(.READ_LATENCY(3)) dut3 (
        .ps_clk(clk), .ps_rst_n(rst_n),
        .s_axil_awaddr(32'h0), .s_axil_awvalid(1'b0), .s_axil_awready(awready3),
        .s_axil_wdata(64'h0), .s_axil_wstrb(8'h00), .s_axil_wvalid(1'b0),
        .s_axil_wready(wready3), .s_axil_bresp(bresp3), .s_axil_bvalid(bvalid3),
        .s_axil_bready(1'b1), .s_axil_araddr(araddr3), .s_axil_arvalid(arvalid3),
        .s_axil_arready(arready3), .s_axil_rdata(rdata3), .s_axil_rresp(rresp3),
        .s_axil_rvalid(rvalid3), .s_axil_rready(1'b1),
        .reg_wen(reg_wen3), .reg_waddr(reg_waddr3), .reg_wdata(reg_wdata3),
        .reg_ren(reg_ren3), .reg_raddr(reg_raddr3), .reg_rdata(reg_rdata3)
    );

    // Register-file models: data is valid only on the single expected cycle.
    localparam logic [63:0] JUNK = 64'hBADD_0000_BADD_0000;
    logic [63:0] rd_value = 64'hDEAD_BEEF_0000_0005;
    logic [3:0]  ren_pipe1 = '0, ren_pipe3 = '0;
    always @(posedge clk) begin
        ren_pipe1 <= {ren_pipe1[2:0], reg_ren1};
        ren_pipe3 <= {ren_pipe3[2:0], reg_ren3};
    end
    assign reg_rdata1 = ren_pipe1[0] ? rd_value : JUNK;
    assign reg_rdata3 = ren_pipe3[2] ? rd_value : JUNK;

    // Strobe monitors
    int wen_cnt1 = 0, ren_cnt1 = 0, ren_cnt3 = 0;
    logic both_hi = 1'b0;
    always @(posedge clk) begin
        if (reg_wen1 === 1'b1) wen_cnt1 <= wen_cnt1 + 1;
        if (reg_ren1 === 1'b1) ren_cnt1 <= ren_cnt1 + 1;
        if (reg_ren3 === 1'b1) ren_cnt3 <= ren_cnt3 + 1;
        if ((reg_wen1 === 1'b1) && (reg_ren1 === 1'b1)) both_hi <= 1'b1;
    end

    int total = 0;
    int bad = 0;
    int base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0: return reg_wen1;
            1: return reg_ren1;
            2: return bvalid1;
            3: return rvalid1;
            4: return reg_ren3;
            5: return rvalid3;
            default: return reg_wen1 | reg_ren1;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sig_sel(which) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {63'd0, seen}, 64'd1);
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        awaddr1 = a; wdata1 = d; wstrb1 = s;
        awvalid1 = 1'b1; wvalid1 = 1'b1;
        tick();
        awvalid1 = 1'b0; wvalid1 = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a);
        araddr1 = a; arvalid1 = 1'b1;
        tick();
        arvalid1 = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_awready", {63'd0, awready1}, 64'd1);
        chk("rst_wready",  {63'd0, wready1},  64'd1);
        chk("rst_arready", {63'd0, arready1}, 64'd1);
        chk("rst_valids",  {60'd0, bvalid1, rvalid1, reg_wen1, reg_ren1}, 64'd0);
        chk("rst_resps",   {60'd0, bresp1, rresp1}, 64'd0);
        chk("rst_rdata",   rdata1, 64'd0);
        chk("rst_regaddr", {32'd0, reg_waddr1, reg_raddr1}, 64'd0);
        chk("rst_wdata",   reg_wdata1, 64'd0);
        rst_n = 1'b1;
        tick();

        // AW and W in the same cycle
        issue_write(32'h20, 64'h0000_0300_0000_0000, 8'hFF);
        chk("t1_awready_low", {63'd0, awready1}, 64'd0);
        chk("t1_wready_low",  {63'd0, wready1},  64'd0);
        wait_for(0, "t1_wen_seen");
        chk("t1_waddr", {48'd0, reg_waddr1}, 64'h20);
        chk("t1_wdata", reg_wdata1, 64'h0000_0300_0000_0000);
        chk("t1_bvalid_not_yet", {63'd0, bvalid1}, 64'd0);
        tick();
        chk("t1_wen_single", {63'd0, reg_wen1}, 64'd0);
        chk("t1_bvalid", {63'd0, bvalid1}, 64'd1);
        chk("t1_bresp", {62'd0, bresp1}, 64'd0);
        tick();
        chk("t1_b_done", {61'd0, bvalid1, awready1, wready1}, 64'b011);
        chk("t1_wen_cnt", 64'(wen_cnt1), 64'd1);

        // W two cycles before AW
        base = wen_cnt1;
        wdata1 = 64'h1111_2222_3333_4444; wstrb1 = 8'hFF; wvalid1 = 1'b1;
        tick();
        wvalid1 = 1'b0;
        chk("t2_wready_low", {63'd0, wready1}, 64'd0);
        tick(); tick();
        chk("t2_no_early_wen", 64'(wen_cnt1 - base), 64'd0);
        awaddr1 = 32'h08; awvalid1 = 1'b1;
        tick();
        awvalid1 = 1'b0;
        wait_for(0, "t2_wen_seen");
        chk("t2_waddr", {48'd0, reg_waddr1}, 64'h08);
        chk("t2_wdata", reg_wdata1, 64'h1111_2222_3333_4444);
        chk("t2_wready_held", {63'd0, wready1}, 64'd0);
        tick();
        chk("t2_bvalid", {63'd0, bvalid1}, 64'd1);
        chk("t2_bresp", {62'd0, bresp1}, 64'd0);
        tick();
        chk("t2_wready_back", {62'd0, bvalid1, wready1}, 64'b01);
        chk("t2_wen_cnt", 64'(wen_cnt1 - base), 64'd1);

        // Read, latency 1
        issue_read(32'h50);
        chk("t3_arready_low", {63'd0, arready1}, 64'd0);
        wait_for(1, "t3_ren_seen");
        chk("t3_raddr", {48'd0, reg_raddr1}, 64'h50);
        wait_for(3, "t3_rvalid_seen");
        chk("t3_rdata", rdata1, 64'hDEAD_BEEF_0000_0005);
        chk("t3_rresp", {62'd0, rresp1}, 64'd0);
        tick();
        chk("t3_r_done", {62'd0, rvalid1, arready1}, 64'b01);

        // Read, latency 3
        araddr3 = 32'h50; arvalid3 = 1'b1;
        tick();
        arvalid3 = 1'b0;
        wait_for(4, "t3l3_ren_seen");
        chk("t3l3_raddr", {48'd0, reg_raddr3}, 64'h50);
        wait_for(5, "t3l3_rvalid_seen");
        chk("t3l3_rdata", rdata3, 64'hDEAD_BEEF_0000_0005);
        chk("t3l3_rresp", {62'd0, rresp3}, 64'd0);
        tick();

        // Contention after reset: write first, then read first
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        awaddr1 = 32'h68; wdata1 = 64'hA5A5_0000_0000_0068; wstrb1 = 8'hFF;
        araddr1 = 32'h38;
        awvalid1 = 1'b1; wvalid1 = 1'b1; arvalid1 = 1'b1;
        tick();
        awvalid1 = 1'b0; wvalid1 = 1'b0; arvalid1 = 1'b0;
        wait_for(6, "t4_first_strobe");
        chk("t4_first_is_write", {62'd0, reg_wen1, reg_ren1}, 64'b10);
        chk("t4_waddr", {48'd0, reg_waddr1}, 64'h68);
        wait_for(2, "t4_bvalid_seen");
        tick();
        wait_for(1, "t4_ren_seen");
        chk("t4_raddr", {48'd0, reg_raddr1}, 64'h38);
        wait_for(3, "t4_rvalid_seen");
        tick();
        awaddr1 = 32'h70; wdata1 = 64'h5A5A_0000_0000_0070;
        araddr1 = 32'h18;
        awvalid1 = 1'b1; wvalid1 = 1'b1; arvalid1 = 1'b1;
        tick();
        awvalid1 = 1'b0; wvalid1 = 1'b0; arvalid1 = 1'b0;
        wait_for(6, "t4b_first_strobe");
        chk("t4b_first_is_read", {62'd0, reg_wen1, reg_ren1}, 64'b01);
        chk("t4b_raddr", {48'd0, reg_raddr1}, 64'h18);
        wait_for(3, "t4b_rvalid_seen");
        tick();
        wait_for(0, "t4b_wen_seen");
        chk("t4b_waddr", {48'd0, reg_waddr1}, 64'h70);
        wait_for(2, "t4b_bvalid_seen");
        tick();

        // Error responses and window boundary
        base = wen_cnt1;
        issue_write(32'h10, 64'h1, 8'h0F);
        wait_for(2, "t5_strb_bvalid");
        chk("t5_strb_bresp", {62'd0, bresp1}, 64'b10);
        chk("t5_strb_no_wen", 64'(wen_cnt1 - base), 64'd0);
        tick();
        base = ren_cnt1;
        issue_read(32'h44);
        wait_for(3, "t5_unal_rvalid");
        chk("t5_unal_rresp", {62'd0, rresp1}, 64'b10);
        chk("t5_unal_rdata", rdata1, 64'd0);
        chk("t5_unal_no_ren", 64'(ren_cnt1 - base), 64'd0);
        tick();
        base = wen_cnt1;
        issue_write(32'h100, 64'h2, 8'hFF);
        wait_for(2, "t5_dec_bvalid");
        chk("t5_dec_bresp", {62'd0, bresp1}, 64'b11);
        chk("t5_dec_no_wen", 64'(wen_cnt1 - base), 64'd0);
        tick();
        issue_read(32'h80);
        wait_for(3, "t5_rdec_rvalid");
        chk("t5_rdec_rresp", {62'd0, rresp1}, 64'b11);
        tick();
        issue_write(32'h78, 64'h3, 8'hFF);
        wait_for(0, "t5_last_wen");
        chk("t5_last_waddr", {48'd0, reg_waddr1}, 64'h78);
        wait_for(2, "t5_last_bvalid");
        chk("t5_last_bresp", {62'd0, bresp1}, 64'd0);
        tick();

        // B backpressure
        bready1 = 1'b0;
        issue_write(32'h30, 64'h4, 8'hFF);
        wait_for(2, "t6_bvalid_seen");
        awaddr1 = 32'h40; awvalid1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_bvalid_hold", {63'd0, bvalid1}, 64'd1);
            chk("t6_bresp_hold", {62'd0, bresp1}, 64'd0);
            chk("t6_aw_blocked", {63'd0, awready1}, 64'd0);
        end
        awvalid1 = 1'b0;
        bready1 = 1'b1;
        tick();
        chk("t6_b_done", {62'd0, bvalid1, awready1}, 64'b01);

        // Reset during RD_WAIT on the latency-3 instance
        araddr3 = 32'h50; arvalid3 = 1'b1;
        tick();
        arvalid3 = 1'b0;
        wait_for(4, "t7_ren_seen");
        tick();
        base = ren_cnt3;
        rst_n = 1'b0;
        #1;
        chk("t7_rvalid_low", {63'd0, rvalid3}, 64'd0);
        chk("t7_readies", {61'd0, awready3, wready3, arready3}, 64'b111);
        tick(); tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t7_no_ren_after", 64'(ren_cnt3 - base), 64'd0);
        chk("t7_no_rvalid_after", {63'd0, rvalid3}, 64'd0);

        chk("wen_ren_exclusive", {63'd0, both_hi}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
